// File: rtl/sram_port_ctrl.sv
// Valid/ready front end for a single-port OpenRAM-style SRAM macro: one access per cycle,
// a one-slot capture stage and a 3-entry in-order response FIFO with credit-based back-pressure.
module sram_port_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15,
  parameter int NUM_WMASKS = 4,
  parameter int MEM_WORDS  = 1 << ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH+1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_WMASKS-1:0]   req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    sram_csb,
  output logic                    sram_web,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_din,
  output logic [NUM_WMASKS-1:0]   sram_wmask,
  input  logic [DATA_WIDTH-1:0]   sram_dout
);

  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS);

  logic                  s1_valid_r;
  logic                  s1_read_r;
  logic                  s1_err_r;
  logic [1:0]            fifo_count_r;
  logic [1:0]            wr_ptr_r;
  logic [1:0]            rd_ptr_r;
  logic [DATA_WIDTH-1:0] fifo_data_r [0:2];
  logic                  fifo_err_r  [0:2];

  logic [ADDR_WIDTH-1:0] word_addr_s;
  logic                  in_range_s;
  logic                  noop_write_s;
  logic                  fire_s;
  logic                  push_s;
  logic                  pop_s;
  logic [DATA_WIDTH-1:0] push_rdata_s;

  assign word_addr_s  = req_addr[ADDR_WIDTH+1:2];
  assign in_range_s   = {1'b0, word_addr_s} < MEM_LIMIT;
  assign noop_write_s = req_we && (req_wstrb == {NUM_WMASKS{1'b0}});

  // Credit counts every accepted-but-unconsumed response, so the FIFO can never overflow.
  assign req_ready = !rst && (({2'b00, s1_valid_r} + {1'b0, fifo_count_r}) < 3'd3);
  assign fire_s    = req_valid && req_ready;

  assign sram_csb   = !(fire_s && in_range_s && !noop_write_s);
  assign sram_web   = !req_we;
  assign sram_addr  = word_addr_s;
  assign sram_din   = req_wdata;
  assign sram_wmask = req_wstrb;

  assign push_s       = s1_valid_r;
  assign push_rdata_s = s1_read_r ? sram_dout : {DATA_WIDTH{1'b0}};
  assign rsp_valid    = fifo_count_r != 2'd0;
  assign pop_s        = rsp_valid && rsp_ready;
  assign rsp_rdata    = rsp_valid ? fifo_data_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};
  assign rsp_err      = rsp_valid ? fifo_err_r[rd_ptr_r] : 1'b0;

  // Capture stage, FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r   <= 1'b0;
      s1_read_r    <= 1'b0;
      s1_err_r     <= 1'b0;
      fifo_count_r <= 2'd0;
      wr_ptr_r     <= 2'd0;
      rd_ptr_r     <= 2'd0;
    end else begin
      s1_valid_r <= fire_s;
      s1_read_r  <= fire_s && !req_we && in_range_s;
      s1_err_r   <= fire_s && !in_range_s;
      if (push_s) begin
        wr_ptr_r <= (wr_ptr_r == 2'd2) ? 2'd0 : wr_ptr_r + 2'd1;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == 2'd2) ? 2'd0 : rd_ptr_r + 2'd1;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + 2'd1;
        2'b01:   fifo_count_r <= fifo_count_r - 2'd1;
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

  // Response storage; contents are only visible while the matching entry is counted.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_data_r[wr_ptr_r] <= push_rdata_s;
      fifo_err_r[wr_ptr_r]  <= s1_err_r;
    end
  end

endmodule
